// File: rtl/midi_event_tx_pkg.sv
// MIDI transmit shared definitions: event codes, status nibbles,
// default clocking and the byte builders used by midi_event_tx.
package midi_event_tx_pkg;

  localparam int DEF_CLK_FREQ = 16000000;
  localparam int DEF_BAUD     = 31250;

  // Index of the stop bit within a 10-bit 8N1 frame.
  localparam logic [3:0] STOP_BIT_IDX = 4'd9;

  typedef enum logic [1:0] {
    EV_NOTE_OFF = 2'd0,
    EV_NOTE_ON  = 2'd1,
    EV_CC       = 2'd2,
    EV_PROG     = 2'd3
  } ev_type_e;

  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_CC       = 4'hB;
  localparam logic [3:0] ST_PROG     = 4'hC;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STATUS,
    S_D1,
    S_D2
  } tx_state_e;

  function automatic logic [7:0] status_byte(
    input logic [1:0] t,
    input logic [3:0] ch
  );
    logic [3:0] hi;
    hi = ST_NOTE_OFF;
    unique case (t)
      EV_NOTE_OFF: hi = ST_NOTE_OFF;
      EV_NOTE_ON:  hi = ST_NOTE_ON;
      EV_CC:       hi = ST_CC;
      EV_PROG:     hi = ST_PROG;
      default:     hi = ST_NOTE_OFF;
    endcase
    return {hi, ch};
  endfunction

  function automatic logic [7:0] data_byte(
    input logic [6:0] d
  );
    return {1'b0, d};
  endfunction

endpackage

// File: rtl/midi_event_tx_uart_tx_byte.sv
// 8N1 UART byte transmitter used by midi_event_tx.
// Ports: clk, rst (async high), start, data[7:0] in; tx, done, idle out.
//   done is high during the final clock of the stop bit; a start
//   in that same clock chains the next frame with no gap.
module uart_tx_byte
  import midi_event_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic       idle
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

  logic          active;
  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shift;
  logic          bit_end;
  logic          load;

  assign bit_end = active && (clk_cnt == LAST_CLK);
  assign done    = bit_end && (bit_cnt == STOP_BIT_IDX);
  assign idle    = !active;
  assign load    = start && (!active || done);

  // shift holds the bits still to go out after the current one;
  // a 1 is fed in at the top so the stop bit falls out last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '1;
      tx      <= 1'b1;
    end else if (load) begin
      active  <= 1'b1;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= {1'b1, data};
      tx      <= 1'b0;
    end else if (done) begin
      active  <= 1'b0;
      clk_cnt <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
    end else if (bit_end) begin
      clk_cnt <= '0;
      bit_cnt <= bit_cnt + 4'd1;
      shift   <= {1'b1, shift[8:1]};
      tx      <= shift[0];
    end else if (active) begin
      clk_cnt <= clk_cnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/midi_event_tx.sv
// MIDI channel-voice event serialiser: one event per valid/ready
// handshake, sent as status + data bytes on a 31250-baud 8N1 line.
// Ports: clk, rst (async high), ev_valid/ev_ready handshake,
//   ev_type[1:0], ev_channel[3:0], ev_data1[6:0], ev_data2[6:0] in;
//   serial_tx (idles high), busy out.
// Option: define MIDI_TX_RUNNING_STATUS_EN to omit a status byte
//   equal to the previously transmitted one.
module midi_event_tx
  import midi_event_tx_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic [1:0] ev_type,
  input  logic [3:0] ev_channel,
  input  logic [6:0] ev_data1,
  input  logic [6:0] ev_data2,
  output logic       serial_tx,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

  tx_state_e  state;
  tx_state_e  state_nxt;
  logic [6:0] d1_q;
  logic [6:0] d2_q;
  logic       is_prog_q;
  logic       accept;
  logic       skip;
  logic [7:0] status_now;
  logic       u_start;
  logic [7:0] u_data;
  logic       u_done;
  logic       u_idle;

  assign status_now = status_byte(ev_type, ev_channel);
  assign ev_ready   = (state == S_IDLE) && u_idle;
  assign accept     = ev_valid && ev_ready;
  assign busy       = (state != S_IDLE);

`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0] last_status;

  // 0x00 is never a status byte, so a cleared register never matches.
  assign skip = (status_now == last_status);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_status <= 8'h00;
    else if (accept && !skip)
      last_status <= status_now;
  end
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1_q      <= '0;
      d2_q      <= '0;
      is_prog_q <= 1'b0;
    end else if (accept) begin
      d1_q      <= ev_data1;
      d2_q      <= ev_data2;
      is_prog_q <= (ev_type == EV_PROG);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (accept)
          state_nxt = skip ? S_D1 : S_STATUS;
      S_STATUS:
        if (u_done)
          state_nxt = S_D1;
      S_D1:
        if (u_done)
          state_nxt = is_prog_q ? S_IDLE : S_D2;
      S_D2:
        if (u_done)
          state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  // The first byte is loaded on the acceptance edge and each later
  // byte on the done clock of its predecessor, so frames abut.
  always_comb begin
    u_start = 1'b0;
    u_data  = 8'h00;
    unique case (state)
      S_IDLE: begin
        u_start = accept;
        u_data  = skip ? data_byte(ev_data1) : status_now;
      end
      S_STATUS: begin
        u_start = u_done;
        u_data  = data_byte(d1_q);
      end
      S_D1: begin
        u_start = u_done && !is_prog_q;
        u_data  = data_byte(d2_q);
      end
      default: begin
        u_start = 1'b0;
        u_data  = 8'h00;
      end
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clk),
    .rst  (rst),
    .start(u_start),
    .data (u_data),
    .tx   (serial_tx),
    .done (u_done),
    .idle (u_idle)
  );

endmodule

// File: tb/tb_midi_event_tx.sv
// Bench for midi_event_tx: bit-stream model, per-cycle line check,
// UART byte decoder and hand-computed byte/timing expectations.
module tb_midi_event_tx;

  localparam int CLK_FREQ = 4000000;
  localparam int BAUD     = 31250;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int LIMIT    = 40 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ev_valid = 1'b0;
  logic [1:0] ev_type = 2'd0;
  logic [3:0] ev_channel = 4'd0;
  logic [6:0] ev_data1 = 7'd0;
  logic [6:0] ev_data2 = 7'd0;
  logic       ev_ready;
  logic       serial_tx;
  logic       busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  midi_event_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_type   (ev_type),
    .ev_channel(ev_channel),
    .ev_data1  (ev_data1),
    .ev_data2  (ev_data2),
    .serial_tx (serial_tx),
    .busy      (busy)
  );

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: the line as a queue of frame bits, each lasting CPB clocks.
  bit   mq[$];
  int   mcnt = 0;
  int   acc_cnt = 0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0] m_last = 8'h00;
`endif

  function automatic logic [7:0] stat(
    input logic [1:0] t,
    input logic [3:0] ch
  );
    case (t)
      2'd0:    return {4'h8, ch};
      2'd1:    return {4'h9, ch};
      2'd2:    return {4'hB, ch};
      default: return {4'hC, ch};
    endcase
  endfunction

  task automatic push_byte(input logic [7:0] b);
    mq.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      mq.push_back(b[i]);
    mq.push_back(1'b1);
  endtask

  always @(posedge clk) begin
    bit         was_empty;
    logic [7:0] st;
    if (rst) begin
      mq.delete();
      mcnt = 0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
      m_last = 8'h00;
`endif
    end else begin
      was_empty = (mq.size() == 0);
      if (!was_empty) begin
        mcnt++;
        if (mcnt == CPB) begin
          mcnt = 0;
          void'(mq.pop_front());
        end
      end
      if (ev_valid && was_empty) begin
        st = stat(ev_type, ev_channel);
`ifdef MIDI_TX_RUNNING_STATUS_EN
        if (st != m_last)
          push_byte(st);
        m_last = st;
`else
        push_byte(st);
`endif
        push_byte({1'b0, ev_data1});
        if (ev_type != 2'd3)
          push_byte({1'b0, ev_data2});
        acc_cnt++;
      end
    end
  end

  // Per-cycle compare of {serial_tx, busy, ev_ready} against the model.
  always @(negedge clk) begin
    logic [2:0] e;
    if (rst)
      e = 3'b101;
    else if (mq.size() != 0)
      e = {mq[0], 2'b10};
    else
      e = 3'b101;
    check("line", {29'd0, serial_tx, busy, ev_ready}, {29'd0, e});
  end

  // Independent UART decoder sampling mid-bit.
  logic [7:0] rxq[$];
  bit         rx_on = 0;
  int         rx_t = 0;
  int         rx_k = 0;
  logic [7:0] rx_b = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      rx_on = 0;
    end else if (!rx_on) begin
      if (serial_tx === 1'b0) begin
        rx_on = 1;
        rx_t  = 0;
      end
    end else begin
      rx_t++;
      if (rx_t % CPB == CPB / 2) begin
        rx_k = rx_t / CPB;
        if (rx_k >= 1 && rx_k <= 8)
          rx_b = {serial_tx, rx_b[7:1]};
        else if (rx_k == 9) begin
          rxq.push_back(rx_b);
          rx_on = 0;
        end
      end
    end
  end

  // Busy run length and the idle gap preceding the latest run.
  int bz_run = 0;
  int bz_low = 0;
  int last_len = 0;
  int last_gap = 0;

  always @(negedge clk) begin
    if (rst) begin
      bz_run = 0;
      bz_low = 0;
    end else if (busy) begin
      if (bz_run == 0)
        last_gap = bz_low;
      bz_run++;
      bz_low = 0;
    end else begin
      if (bz_run != 0)
        last_len = bz_run;
      bz_run = 0;
      bz_low++;
    end
  end

  logic [7:0] expq[$];

  task automatic offer(
    input logic [1:0] t,
    input logic [3:0] ch,
    input logic [6:0] a,
    input logic [6:0] b
  );
    ev_type    = t;
    ev_channel = ch;
    ev_data1   = a;
    ev_data2   = b;
    ev_valid   = 1'b1;
  endtask

  task automatic wait_acc(input int target);
    int n;
    n = 0;
    while (acc_cnt < target && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("accept", acc_cnt, target);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((mq.size() != 0 || busy) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("idle in time", 32'(n < LIMIT), 32'd1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic cmp_bytes(input string name);
    check({name, " count"}, rxq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < rxq.size(); i++)
      check(name, 32'(rxq[i]), 32'(expq[i]));
    rxq.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset outputs", {29'd0, serial_tx, busy, ev_ready},
          32'd5);
    rst = 1'b0;
    @(negedge clk);

    offer(2'd1, 4'd0, 7'd60, 7'd100);
    wait_acc(1);
    ev_valid = 1'b0;
    wait_idle();
    expq = '{8'h90, 8'h3C, 8'h64};
    cmp_bytes("note on bytes");
    check("note on busy clocks", last_len, 30 * CPB);
    check("ready after msg", 32'(ev_ready), 32'd1);

    offer(2'd3, 4'd9, 7'd5, 7'h55);
    wait_acc(2);
    ev_valid = 1'b0;
    wait_idle();
    expq = '{8'hC9, 8'h05};
    cmp_bytes("prog bytes");
    check("prog busy clocks", last_len, 20 * CPB);

    offer(2'd1, 4'd3, 7'd64, 7'd90);
    wait_acc(3);
    ev_data1 = 7'd67;
    wait_acc(4);
    ev_valid = 1'b0;
    wait_idle();
`ifdef MIDI_TX_RUNNING_STATUS_EN
    expq = '{8'h93, 8'h40, 8'h5A, 8'h43, 8'h5A};
    check("b2b second len", last_len, 20 * CPB);
`else
    expq = '{8'h93, 8'h40, 8'h5A, 8'h93, 8'h43, 8'h5A};
    check("b2b second len", last_len, 30 * CPB);
`endif
    cmp_bytes("b2b bytes");
    check("b2b idle gap", last_gap, 1);

    offer(2'd1, 4'd1, 7'd48, 7'd64);
    wait_acc(5);
    ev_valid = 1'b0;
    repeat (1999) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("mid reset outputs",
             {29'd0, serial_tx, busy, ev_ready}, 32'd5);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rxq.delete();
    @(negedge clk);
    offer(2'd1, 4'd1, 7'd48, 7'd64);
    wait_acc(6);
    ev_valid = 1'b0;
    wait_idle();
    expq = '{8'h91, 8'h30, 8'h40};
    cmp_bytes("after reset bytes");

    offer(2'd0, 4'd2, 7'd10, 7'd20);
    wait_acc(7);
    ev_valid = 1'b0;
    repeat (500) @(negedge clk);
    offer(2'd3, 4'd5, 7'd1, 7'd2);
    @(negedge clk);
    ev_valid = 1'b0;
    wait_idle();
    expq = '{8'h82, 8'h0A, 8'h14};
    cmp_bytes("dropped pulse bytes");
    check("dropped not accepted", acc_cnt, 7);

    offer(2'd2, 4'd15, 7'h7F, 7'h00);
    wait_acc(8);
    ev_valid = 1'b0;
    wait_idle();
    if (rxq.size() == 3) begin
      check("cc d1 bit7", 32'(rxq[1][7]), 32'd0);
      check("cc d2 bit7", 32'(rxq[2][7]), 32'd0);
    end else begin
      check("cc byte total", rxq.size(), 3);
    end
    expq = '{8'hBF, 8'h7F, 8'h00};
    cmp_bytes("cc bytes");
    check("cc busy clocks", last_len, 30 * CPB);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/midi_event_tx.md
Name: midi_event_tx

Overview:
Serialises MIDI channel-voice events into a 31250-baud MIDI byte stream on the serial_tx line. It is the transmit counterpart of the midi_player receive path. Upstream logic (sequencer, arpeggiator, note-echo) presents one event per valid/ready handshake. The block builds the status and data bytes and shifts them out as 8N1 UART frames.

Parameters:
CLK_FREQ, 16000000, system clock frequency in Hz.
BAUD, 31250, MIDI bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD (512 at defaults), fixed at elaboration.

Ports:
clk  input  1  system clock (16 MHz).
rst  input  1  asynchronous, active-high reset.
ev_valid  input  1  event present.
ev_ready  output  1  block can accept an event this cycle.
ev_type  input  2  0=note off, 1=note on, 2=control change, 3=program change.
ev_channel  input  4  MIDI channel 0-15.
ev_data1  input  7  note number / controller number / program number.
ev_data2  input  7  velocity / controller value; ignored for program change.
serial_tx  output  1  MIDI UART out; idles high.
busy  output  1  high while any byte of a message is being transmitted.

Behaviour:
- Reset (async assert, sync release): serial_tx=1, ev_ready=1, busy=0, FSM=IDLE, bit counters cleared, last_status cleared to 0x00 (invalid).
- Handshake: an event is accepted on a rising clk edge with ev_valid && ev_ready. All fields are latched at acceptance. ev_ready is 1 only in IDLE. It drops the cycle after acceptance. ev_valid while ev_ready=0 is ignored; the event is not queued.
- Status byte = {1'b1, code[2:0], ev_channel}. Codes: note off 3'b000 (0x8n), note on 3'b001 (0x9n), CC 3'b011 (0xBn), program change 3'b100 (0xCn).
- Data bytes = {1'b0, data[6:0]}. Bit 7 is always 0.
- FSM: IDLE -> SEND_STATUS -> SEND_D1 -> SEND_D2 -> IDLE.
  - Program change goes SEND_D1 -> IDLE, with no D2.
  - Each SEND_* state starts one byte on the sub-module and waits for its done pulse.
- UART framing:
  - Start bit 0, then 8 data bits LSB first, then 1 stop bit 1.
  - Each bit is held exactly CLKS_PER_BIT clocks. serial_tx is a registered output.
  - The start bit of the first byte begins on the cycle after the acceptance edge.
  - Consecutive bytes of a message are gapless: the next start bit immediately follows the previous stop bit.
- Timing: a 3-byte message occupies 30*CLKS_PER_BIT = 15360 clocks; a 2-byte message occupies 10240.
- busy rises with the first start bit and falls on the cycle after the last stop bit completes. ev_ready rises that same cycle.
- Back-to-back: if ev_valid is held, the next event is accepted on the first cycle ev_ready=1. The line has a 1-clock idle gap between messages.
- Reset mid-frame: serial_tx returns to 1 immediately (async) and the partial message is discarded. No resume after release.

Optional Feature:
Macro MIDI_TX_RUNNING_STATUS_EN.
- Defined:
  - On acceptance, if the computed status equals last_status, SEND_STATUS is skipped and the FSM goes straight to SEND_D1. A repeated note on/off then costs 2 bytes and 20*CLKS_PER_BIT clocks.
  - last_status is updated on every transmitted status byte and cleared by reset.
- Not defined:
  - The status byte is always sent and last_status logic is absent.

Decomposition:
- Shared package/include (midi_defs.vh): ev_type encodings, the status code nibbles (0x8/0x9/0xB/0xC), and the default CLK_FREQ/BAUD.
- One sub-module, uart_tx_byte:
  - Inputs: clk, rst, start, data[7:0]. Outputs: tx, done (1-cycle pulse at end of stop bit), idle.
  - Owns the baud counter and bit counter.
- midi_event_tx holds only the message FSM, field latches and last_status.

Test Plan:
- Note on, ch0, data1=60, data2=100 -> UART-decoded bytes 0x90,0x3C,0x64. Each bit is 512 clocks; total busy time is 15360 clocks; ev_ready returns 1 after that.
- Program change, ch9, data1=5 -> bytes 0xC9,0x05 only. busy lasts 10240 clocks.
- ev_valid held high with two note-on events on ch3 -> second message starts 1 clock after the first ends.
  - With MIDI_TX_RUNNING_STATUS_EN: second message is data bytes only (0x93 omitted).
  - Without the macro: 0x93 is resent.
- Reset asserted at clock 2000 of a message -> serial_tx=1 in the same cycle, busy=0, ev_ready=1. The next event after release is transmitted in full, status included.
- ev_valid pulsed for 1 cycle while busy=1 -> event dropped, output stream unchanged.
- ev_data1=7'h7F, ev_data2=7'h00 on CC ch15 -> bytes 0xBF,0x7F,0x00. Bit 7 of the data bytes is verified 0.
